// File: rtl/jesd204b_tx_link_ctrl.sv
// Single-lane JESD204B transmit link-layer controller: CGS, ILAS and user-data
// phases sequenced by the receiver's SYNC~ and aligned to a free-running LMFC.
module jesd204b_tx_link_ctrl #(
    parameter int F          = 2,
    parameter int K          = 16,
    parameter int ILAS_MF    = 4,
    parameter int RESYNC_LEN = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         sync_n,
    input  logic [111:0] cfg_data,
    input  logic [7:0]   data_in,
    output logic [7:0]   data_out,
    output logic         k_out,
    output logic         lmfc,
    output logic         link_up,
    output logic [1:0]   state_out
);

    localparam int OW = (F > 1) ? $clog2(F) : 1;
    localparam int FW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = $clog2(F * K + 1);
    localparam int MW = $clog2(ILAS_MF) + 1;
    localparam int LW = $clog2(RESYNC_LEN + 1);

    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        ST_CGS  = 2'b00,
        ST_ILAS = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic          sync_meta_q, sync_s_q;
    logic [OW-1:0] octet_q, octet_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [MW-1:0] mf_q, mf_d;
    logic [LW-1:0] low_q, low_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          k_out_q, k_out_d;
    logic          lmfc_q, lmfc_d;
    logic          link_up_q, link_up_d;
    logic [1:0]    state_out_q;

    logic          lmfc_last;
    logic [PW-1:0] pos_d;
    logic [3:0]    cfg_idx;

    always_comb begin
        lmfc_last = (octet_q == OW'(F - 1)) && (frame_q == FW'(K - 1));
        octet_d   = octet_q + 1'b1;
        frame_d   = frame_q;
        if (octet_q == OW'(F - 1)) begin
            octet_d = '0;
            frame_d = (frame_q == FW'(K - 1)) ? '0 : frame_q + 1'b1;
        end
        pos_d = PW'(frame_d) * PW'(F) + PW'(octet_d);
    end

    // Phase decisions use the current counters; outputs are decoded from the
    // next state and next position so they line up with the same clock edge.
    always_comb begin
        state_d = state_q;
        mf_d    = mf_q;
        low_d   = low_q;
        case (state_q)
            ST_CGS: begin
                if (sync_s_q && lmfc_last) begin
                    state_d = ST_ILAS;
                    mf_d    = '0;
                end
            end
            ST_ILAS: begin
                if (!sync_s_q) begin
                    state_d = ST_CGS;
                end else if (lmfc_last) begin
                    if (mf_q == MW'(ILAS_MF - 1)) begin
                        state_d = ST_DATA;
                    end else begin
                        mf_d = mf_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                low_d = sync_s_q ? '0 : low_q + 1'b1;
                if (low_d == LW'(RESYNC_LEN)) begin
                    state_d = ST_CGS;
                end
            end
            default: state_d = ST_CGS;
        endcase
        if (state_d != ST_DATA) begin
            low_d = '0;
        end
    end

    always_comb begin
        data_out_d = K28_5;
        k_out_d    = 1'b1;
        cfg_idx    = 4'(pos_d - PW'(2));
        case (state_d)
            ST_ILAS: begin
                if (pos_d == '0) begin
                    data_out_d = K28_0;
                end else if (pos_d == PW'(F * K - 1)) begin
                    data_out_d = K28_3;
                end else if (mf_d == MW'(1) && pos_d == PW'(1)) begin
                    data_out_d = K28_4;
                end else if (mf_d == MW'(1) && pos_d <= PW'(15)) begin
                    data_out_d = cfg_data[{cfg_idx, 3'b000} +: 8];
                    k_out_d    = 1'b0;
                end else begin
                    data_out_d = 8'(pos_d);
                    k_out_d    = 1'b0;
                end
            end
            ST_DATA: begin
                data_out_d = data_in;
                k_out_d    = 1'b0;
            end
            default: ;
        endcase
        lmfc_d    = (pos_d == '0);
        link_up_d = (state_d == ST_DATA);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta_q <= 1'b0;
            sync_s_q    <= 1'b0;
            state_q     <= ST_CGS;
            octet_q     <= '0;
            frame_q     <= '0;
            mf_q        <= '0;
            low_q       <= '0;
            data_out_q  <= K28_5;
            k_out_q     <= 1'b1;
            lmfc_q      <= 1'b0;
            link_up_q   <= 1'b0;
            state_out_q <= 2'b00;
        end else begin
            sync_meta_q <= sync_n;
            sync_s_q    <= sync_meta_q;
            state_q     <= state_d;
            octet_q     <= octet_d;
            frame_q     <= frame_d;
            mf_q        <= mf_d;
            low_q       <= low_d;
            data_out_q  <= data_out_d;
            k_out_q     <= k_out_d;
            lmfc_q      <= lmfc_d;
            link_up_q   <= link_up_d;
            state_out_q <= state_d;
        end
    end

    assign data_out  = data_out_q;
    assign k_out     = k_out_q;
    assign lmfc      = lmfc_q;
    assign link_up   = link_up_q;
    assign state_out = state_out_q;

endmodule

// File: tb/tb_jesd204b_tx_link_ctrl.sv
// Bench for jesd204b_tx_link_ctrl: offset-based link model checked every cycle,
// plus directed literal checks of the CGS/ILAS/DATA sequence.
module tb_jesd204b_tx_link_ctrl;

    localparam int F          = 2;
    localparam int K          = 16;
    localparam int ILAS_MF    = 4;
    localparam int RESYNC_LEN = 4;
    localparam int FK         = F * K;

    logic         clock = 1'b0;
    logic         reset;
    logic         sync_n;
    logic [111:0] cfg_data;
    logic [7:0]   data_in;
    logic [7:0]   data_out;
    logic         k_out;
    logic         lmfc;
    logic         link_up;
    logic [1:0]   state_out;

    int vectors     = 0;
    int miscompares = 0;

    jesd204b_tx_link_ctrl #(
        .F(F),
        .K(K),
        .ILAS_MF(ILAS_MF),
        .RESYNC_LEN(RESYNC_LEN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sync_n(sync_n),
        .cfg_data(cfg_data),
        .data_in(data_in),
        .data_out(data_out),
        .k_out(k_out),
        .lmfc(lmfc),
        .link_up(link_up),
        .state_out(state_out)
    );

    always #5 clock = ~clock;

    always @(negedge clock) data_in = 8'($urandom);

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Link model: sync_s is sync_n two edges late; ILAS is tracked as an octet
    // offset from its first octet, DATA as a run length of low sync_s samples.
    int        m_cyc, m_mode, m_off, m_run, m_pb, m_pa, m_m, m_p;
    bit        m_ss;
    bit        m_hist[$];
    logic [7:0] e_data;
    logic       e_k, e_lmfc, e_link;
    logic [1:0] e_state;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cyc = 0; m_mode = 0; m_off = 0; m_run = 0;
            m_hist.delete();
            e_data = 8'hBC; e_k = 1'b1; e_lmfc = 1'b0; e_link = 1'b0; e_state = 2'b00;
        end else begin
            m_ss = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 1'b0;
            m_hist.push_back(sync_n);
            if (m_hist.size() > 4) void'(m_hist.pop_front());
            m_pb = m_cyc % FK;
            m_pa = (m_cyc + 1) % FK;
            case (m_mode)
                0: if (m_ss && m_pb == FK - 1) begin m_mode = 1; m_off = 0; end
                1: begin
                    if (!m_ss) m_mode = 0;
                    else begin
                        m_off++;
                        if (m_off == ILAS_MF * FK) begin m_mode = 2; m_run = 0; end
                    end
                end
                default: begin
                    m_run = m_ss ? 0 : m_run + 1;
                    if (m_run >= RESYNC_LEN) m_mode = 0;
                end
            endcase
            e_data = 8'hBC; e_k = 1'b1;
            if (m_mode == 1) begin
                m_m = m_off / FK;
                m_p = m_off % FK;
                if (m_p == 0)                              begin e_data = 8'h1C; e_k = 1'b1; end
                else if (m_p == FK - 1)                    begin e_data = 8'h7C; e_k = 1'b1; end
                else if (m_m == 1 && m_p == 1)             begin e_data = 8'h9C; e_k = 1'b1; end
                else if (m_m == 1 && m_p >= 2 && m_p <= 15) begin e_data = cfg_data[(m_p - 2) * 8 +: 8]; e_k = 1'b0; end
                else                                        begin e_data = 8'(m_p); e_k = 1'b0; end
            end else if (m_mode == 2) begin
                e_data = data_in; e_k = 1'b0;
            end
            e_lmfc  = (m_pa == 0);
            e_link  = (m_mode == 2);
            e_state = 2'(m_mode);
            m_cyc++;
        end
    end

    always @(posedge clock) begin
        #1;
        check("data_out", data_out, e_data);
        check("k_out", {7'd0, k_out}, {7'd0, e_k});
        check("lmfc", {7'd0, lmfc}, {7'd0, e_lmfc});
        check("link_up", {7'd0, link_up}, {7'd0, e_link});
        check("state_out", {6'd0, state_out}, {6'd0, e_state});
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic wait_lmfc(input int budget, output int n);
        n = 0;
        do begin @(posedge clock); #1; n++; end while (!lmfc && n < budget);
        if (!lmfc) begin
            vectors++; miscompares++;
            $display("FAIL lmfc_wait: no pulse within %0d cycles", budget);
        end
    endtask

    task automatic lit(input string name, input logic [7:0] d, input logic k, input logic [1:0] st);
        check({name, "_data"}, data_out, d);
        check({name, "_k"}, {7'd0, k_out}, {7'd0, k});
        check({name, "_state"}, {6'd0, state_out}, {6'd0, st});
    endtask

    initial begin
        int n;
        for (int i = 0; i < 14; i++) cfg_data[i * 8 +: 8] = 8'hA0 + 8'(i);
        reset = 1'b0; sync_n = 1'b0; data_in = 8'h00;

        // Reset held: K28.5 idle, no LMFC, link down.
        step(3);
        lit("rst", 8'hBC, 1'b1, 2'b00);
        check("rst_lmfc", {7'd0, lmfc}, 8'd0);
        check("rst_link", {7'd0, link_up}, 8'd0);

        @(negedge clock) reset = 1'b1;
        wait_lmfc(40, n);
        check("lmfc_first_period", 8'(n), 8'd32);
        lit("cgs", 8'hBC, 1'b1, 2'b00);
        wait_lmfc(40, n);
        check("lmfc_period", 8'(n), 8'd32);

        // Release SYNC~ at p=10; ILAS starts on the next multiframe boundary.
        step(10);
        @(negedge clock) sync_n = 1'b1;
        wait_lmfc(40, n);
        check("ilas_start_delay", 8'(n), 8'd22);
        lit("mf0_p0", 8'h1C, 1'b1, 2'b01);
        step(1);  lit("mf0_p1", 8'h01, 1'b0, 2'b01);
        step(29); lit("mf0_p30", 8'h1E, 1'b0, 2'b01);
        step(1);  lit("mf0_p31", 8'h7C, 1'b1, 2'b01);
        step(1);  lit("mf1_p0", 8'h1C, 1'b1, 2'b01);
        step(1);  lit("mf1_p1", 8'h9C, 1'b1, 2'b01);
        step(1);  lit("mf1_p2", 8'hA0, 1'b0, 2'b01);
        step(13); lit("mf1_p15", 8'hAD, 1'b0, 2'b01);
        step(1);  lit("mf1_p16", 8'h10, 1'b0, 2'b01);
        step(15); lit("mf1_p31", 8'h7C, 1'b1, 2'b01);
        step(64); lit("mf3_p31", 8'h7C, 1'b1, 2'b01);
        check("mf3_link", {7'd0, link_up}, 8'd0);
        step(1);
        lit("data_first", data_in, 1'b0, 2'b10);
        check("data_first_link", {7'd0, link_up}, 8'd1);
        check("data_first_lmfc", {7'd0, lmfc}, 8'd1);

        // Short SYNC~ pulses in DATA are error reports only.
        step(5);
        @(negedge clock) sync_n = 1'b0;
        repeat (2) @(negedge clock);
        sync_n = 1'b1;
        step(8);
        check("short2_link", {7'd0, link_up}, 8'd1);
        @(negedge clock) sync_n = 1'b0;
        repeat (3) @(negedge clock);
        sync_n = 1'b1;
        step(8);
        check("short3_link", {7'd0, link_up}, 8'd1);

        // Four low clocks force resync: K28.5 six edges after the fall.
        @(negedge clock) sync_n = 1'b0;
        repeat (4) @(negedge clock);
        sync_n = 1'b1;
        step(1);
        check("resync_e5_link", {7'd0, link_up}, 8'd1);
        step(1);
        lit("resync_e6", 8'hBC, 1'b1, 2'b00);
        check("resync_e6_link", {7'd0, link_up}, 8'd0);

        // Drop SYNC~ during ILAS mf2, then re-release: ILAS restarts at mf0.
        for (int i = 0; i < 3; i++) begin
            wait_lmfc(40, n);
            if (state_out == 2'b01) break;
        end
        lit("ilas2_mf0_p0", 8'h1C, 1'b1, 2'b01);
        step(69);
        @(negedge clock) sync_n = 1'b0;
        step(2);
        check("ilas_drop_e2_state", {6'd0, state_out}, 8'd1);
        step(1);
        lit("ilas_drop_e3", 8'hBC, 1'b1, 2'b00);
        step(5);
        @(negedge clock) sync_n = 1'b1;
        wait_lmfc(40, n);
        check("ilas_restart_delay", 8'(n), 8'd19);
        lit("ilas3_mf0_p0", 8'h1C, 1'b1, 2'b01);
        step(33);
        lit("ilas3_mf1_p1", 8'h9C, 1'b1, 2'b01);

        // Reach DATA, then assert reset mid-frame.
        step(95);
        check("data2_link", {7'd0, link_up}, 8'd1);
        step(7);
        #3 reset = 1'b0;
        #1;
        lit("async_rst", 8'hBC, 1'b1, 2'b00);
        check("async_rst_link", {7'd0, link_up}, 8'd0);
        check("async_rst_lmfc", {7'd0, lmfc}, 8'd0);
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        wait_lmfc(40, n);
        check("post_rst_lmfc", 8'(n), 8'd32);
        step(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/jesd204b_tx_link_ctrl.md
Name: jesd204b_tx_link_ctrl

Overview:
- Single-lane JESD204B transmit link-layer controller, one octet per clock.
- Sits between the scrambler output and the 8B10B encoder `in`/`bit_control` inputs.
- Runs Code Group Synchronisation (CGS), then the Initial Lane Alignment Sequence (ILAS), then passes scrambled user data, under control of the receiver's SYNC~ request.
- Keeps a free-running local multiframe clock (LMFC) that all phase changes align to.

Parameters:
- F, 2, octets per frame (1..256).
- K, 16, frames per multiframe (1..32); F*K must be >= 17.
- ILAS_MF, 4, ILAS length in multiframes (>= 2).
- RESYNC_LEN, 4, consecutive low SYNC~ octet clocks in DATA that force re-synchronisation (>= 2).

Ports:
- clock  in  1  octet clock.
- reset  in  1  asynchronous, active-low reset.
- sync_n  in  1  SYNC~ from receiver, asynchronous, active-low.
- cfg_data  in  112  ILAS link-configuration octets 0..13; octet n is cfg_data[n*8+:8]; held static.
- data_in  in  8  scrambled octet from scrambler.
- data_out  out  8  octet to encoder.
- k_out  out  1  control-character flag to encoder `bit_control`.
- lmfc  out  1  one-cycle pulse while the counters are at position 0 of a multiframe.
- link_up  out  1  high in DATA state.
- state_out  out  2  00 CGS, 01 ILAS, 10 DATA.

Behaviour:
- **Reset (reset=0, async):**
  - state CGS; octet_cnt, frame_cnt, mf_cnt and low_cnt = 0; synchroniser flops = 0 (SYNC~ seen as asserted).
  - data_out=8'hBC, k_out=1, lmfc=0, link_up=0, state_out=00.
  - Reset mid-operation aborts any phase immediately.
- **sync_n synchroniser:** 2-flop, giving sync_s. All decisions use sync_s, so there are 2 cycles of added latency.
- **LMFC counters:**
  - octet_cnt counts 0..F-1; frame_cnt increments when octet_cnt wraps and counts 0..K-1. Both free-run from reset release regardless of state.
  - Position p = frame_cnt*F + octet_cnt.
  - lmfc_last = (octet_cnt==F-1 && frame_cnt==K-1).
  - Registered output lmfc=1 in the cycle where p==0.
- **Outputs:** all registered. The octet presented in a cycle corresponds to the state and counters updated on that same edge.
- **CGS:**
  - Output K28.5 (8'hBC, k=1) every cycle.
  - If sync_s==1 && lmfc_last: go to ILAS with mf_cnt=0. The first ILAS octet appears exactly at p==0.
  - sync_s rising mid-multiframe: stay in CGS until the next lmfc_last.
- **ILAS**, for multiframe m = 0..ILAS_MF-1 at position p:
  - p==0: K28.0 (8'h1C, k=1).
  - p==F*K-1: K28.3 (8'h7C, k=1).
  - m==1, p==1: K28.4 (8'h9C, k=1).
  - m==1, p in 2..15: cfg_data octet p-2, k=0.
  - Otherwise: p[7:0] as a data ramp, k=0.
  - mf_cnt increments at each lmfc_last. At lmfc_last with mf_cnt==ILAS_MF-1, go to DATA.
  - sync_s==0 at any cycle in ILAS: go to CGS next cycle, with K28.5 output from that cycle.
- **DATA:**
  - data_out = data_in from the previous cycle, i.e. 1-cycle latency, k_out=0. No character replacement.
  - link_up=1 from the first DATA octet.
  - low_cnt counts consecutive sync_s==0 cycles and clears on sync_s==1.
  - low_cnt reaching RESYNC_LEN: go to CGS, link_up=0 the same cycle K28.5 appears.
  - Shorter low pulses (error reports) are ignored; data continues.
- **Simultaneous events:** sync_s falling on the lmfc_last that would end ILAS means CGS wins (DATA is never entered). In CGS, sync_s==0 on lmfc_last keeps CGS.
- **mf_cnt width:** $clog2(ILAS_MF)+1. It is cleared on entry to ILAS.

Test Plan:
1. Reset held low, sync_n=0 -> data_out=BC, k_out=1 every cycle; lmfc pulses every 32 cycles (F=2, K=16); link_up=0, state_out=00.
2. Release sync_n mid-multiframe (p=10) -> CGS continues to the boundary; the first ILAS octet is 1C/k at the next lmfc pulse; octets 1..30 of mf0 read 01..1E/k=0; octet 31 is 7C/k.
3. ILAS mf1 with cfg_data octets = 8'hA0+n -> p1=9C/k, p2..15=A0..AD/k=0, p16=10, p31=7C/k; 128 ILAS cycles total; first DATA octet at the 5th lmfc pulse equals data_in from the prior cycle; link_up=1.
4. In DATA, sync_n low for 2 octet clocks -> data continues, link_up stays 1. sync_n low for 4 clocks -> link_up falls, BC/k resumes 2+4 cycles after the sync_n fall.
5. sync_n dropped during ILAS mf2 -> BC/k the cycle after sync_s falls. Re-release -> full ILAS restarts at mf0 at the next LMFC boundary.
6. Assert reset during DATA mid-frame -> outputs immediately BC/k, link_up=0, counters 0. After release, lmfc first pulses at p==0 per the fresh counters.
